cnt_uart_tx: RTL and testbench
==============================

Name: cnt_uart_tx

Overview:
Serial reporting stage directly downstream of the 8-bit loadable counter. On a snapshot request it captures the counter's data_cnt output and transmits the value as one UART 8N1 frame, LSB first, on a single txd line. It lets the counter value be observed off-chip or by a bench UART monitor without a parallel bus.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..65535; small default keeps simulation short.
DATA_W, 8, snapshot and frame data width; matches the counter output width.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
data_cnt  input  DATA_W  counter value from the upstream counter.
snap  input  1  single-cycle request to capture data_cnt and start a frame.
clr_ovr  input  1  clears the sticky overrun flag.
txd  output  1  serial line; idles high.
busy  output  1  high while a frame is in progress.
done  output  1  one-cycle pulse at frame completion.
overrun  output  1  sticky; set when snap arrives while busy.

Behaviour:
- Reset values on the first edge with reset=1:
  - txd=1, busy=0, done=0, overrun=0.
  - state=IDLE; shift register and all counters cleared.
- Reset overrides everything, including mid-frame. txd returns high on that edge and no done pulse is produced.
- States:
  - IDLE: txd=1, busy=0.
    - snap=1: latch data_cnt into the shift register, clear the bit-period and bit-index counters, go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: txd=shift[0] for CLKS_PER_BIT cycles per bit.
    - At the end of each bit period: shift right, bit index +1.
    - After bit DATA_W-1, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles, then IDLE with done=1 for exactly that one cycle.
- Latency: snap sampled at edge N puts txd=0 and busy=1 from edge N (visible after N).
- Frame length: (DATA_W+2)*CLKS_PER_BIT cycles of busy=1. busy falls on the same edge that done rises.
- Bit-period counter: width clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. Bit index wraps to 0 on entering STOP.
- Snapshot is taken only on acceptance. Later data_cnt changes, including a counter write during the frame, do not affect the frame in flight.
- snap while busy=1:
  - The request is ignored and overrun is set.
  - A snap on the done cycle is accepted, because the state is IDLE, and does not set overrun.
- overrun:
  - clr_ovr=1 clears it.
  - Simultaneous clr_ovr and set: set wins and overrun stays 1.
- Outputs are registered; txd has no combinational path from any input.

Decomposition:
- Package cnt_uart_pkg holds:
  - state enum {IDLE, START, DATA, STOP};
  - default constants CNT_W=8 and CLKS_PER_BIT_DEF=16;
  - a clog2-based width helper.
- One sub-module is natural: cnt_uart_baud.
  - Bit-period timer with enable and clear inputs.
  - Emits a one-cycle bit_end pulse when the count reaches CLKS_PER_BIT-1.
- The FSM and shift register stay in cnt_uart_tx.

Test Plan:
1. Reset held 3 cycles mid-idle, then released -> txd=1, busy=0, done=0, overrun=0 throughout.
2. CLKS_PER_BIT=4, data_cnt=8'h55, snap one cycle -> txd shows 0 (start), then 1,0,1,0,1,0,1,0, then 1 (stop), each held 4 cycles. busy=1 for 40 cycles; done pulses once as busy falls.
3. Snapshot hold: data_cnt=8'hA3 at snap, then the counter is loaded with 8'h00 two cycles later -> decoded frame byte is 8'hA3.
4. Overrun handling:
   - snap again 10 cycles into a frame -> frame unchanged and overrun=1.
   - clr_ovr pulse -> overrun=0.
   - clr_ovr and snap-while-busy on the same cycle -> overrun=1.
5. Back-to-back: snap asserted on the done cycle with data_cnt=8'h0F -> a new start bit begins immediately, and a second frame decodes 8'h0F with no idle gap.
6. Reset 15 cycles into a frame -> txd=1 and busy=0 on the next edge, no done pulse; a following snap with 8'hFF transmits correctly.

Source files
------------

// File: rtl/cnt_uart_pkg.sv
// Shared types and constants for the counter UART reporting stage.
package cnt_uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int CNT_W            = 8;
  localparam int CLKS_PER_BIT_DEF = 16;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int width_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cnt_uart_tx_if.sv
// Snapshot request / serial status bundle between the counter side and the UART.
interface cnt_uart_tx_if
  import cnt_uart_pkg::*;
#(
  parameter int DATA_W = CNT_W
);
  logic [DATA_W-1:0] data_cnt;
  logic              snap;
  logic              clr_ovr;
  logic              txd;
  logic              busy;
  logic              done;
  logic              overrun;

  modport master (
    output data_cnt, snap, clr_ovr,
    input  txd, busy, done, overrun
  );

  modport slave (
    input  data_cnt, snap, clr_ovr,
    output txd, busy, done, overrun
  );
endinterface

// File: rtl/cnt_uart_baud.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, pulses bit_end on the last count.
module cnt_uart_baud
  import cnt_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic bit_end
);

  localparam int            CW   = width_of(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_end = en && (cnt == LAST);

  // Period counter; wraps to zero on each bit boundary, clear restarts a frame.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= bit_end ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cnt_uart_tx.sv
// Captures the counter value on snap and sends it as one 8N1 UART frame, LSB first.
module cnt_uart_tx
  import cnt_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_W       = CNT_W
) (
  input logic          clk,
  input logic          reset,
  cnt_uart_tx_if.slave bus
);

  localparam int               IDX_W    = width_of(DATA_W);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_W - 1);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shift, shift_nxt;
  logic [IDX_W-1:0]  bit_idx, bit_idx_nxt;
  logic              bit_end;
  logic              accept;
  logic              ovr_set;
  logic              txd_nxt, busy_nxt, done_nxt;
  logic              txd_q, busy_q, done_q, ovr_q;

  // A request is taken only from IDLE; any other request is an overrun.
  assign accept  = (state == IDLE) && bus.snap;
  assign ovr_set = (state != IDLE) && bus.snap;

  cnt_uart_baud #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .en     (state != IDLE),
    .clr    (accept),
    .bit_end(bit_end)
  );

  // State, shift register and bit index.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      shift   <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_nxt;
      shift   <= shift_nxt;
      bit_idx <= bit_idx_nxt;
    end
  end

  // Next-state, shift and bit-index logic; advances only on bit boundaries.
  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    bit_idx_nxt = bit_idx;
    case (state)
      IDLE: begin
        if (bus.snap) begin
          state_nxt   = START;
          shift_nxt   = bus.data_cnt;
          bit_idx_nxt = '0;
        end
      end
      START: begin
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_nxt = shift >> 1;
          if (bit_idx == LAST_BIT) begin
            state_nxt   = STOP;
            bit_idx_nxt = '0;
          end else begin
            bit_idx_nxt = bit_idx + 1'b1;
          end
        end
      end
      STOP: begin
        if (bit_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up with it.
  always_comb begin
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state == STOP) && bit_end;
    case (state_nxt)
      START:   txd_nxt = 1'b0;
      DATA:    txd_nxt = shift_nxt[0];
      default: txd_nxt = 1'b1;
    endcase
  end

  // Output registers; overrun set has priority over clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      txd_q  <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      txd_q  <= txd_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
      if (ovr_set) begin
        ovr_q <= 1'b1;
      end else if (bus.clr_ovr) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign bus.txd     = txd_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.overrun = ovr_q;

endmodule

// File: tb/tb_cnt_uart_tx.sv
// Bench for cnt_uart_tx: directed stimulus with a queue-based frame scoreboard.
module tb_cnt_uart_tx;
  import cnt_uart_pkg::*;

  localparam int CPB = 4;
  localparam int DW  = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  cnt_uart_tx_if #(.DATA_W(DW)) bus();

  cnt_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_W      (DW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int         n_pass      = 0;
  int         n_total     = 0;
  int         frames_done = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One-cycle snap; the byte is queued only when a new frame is expected from it.
  task automatic snap_pulse(input logic [7:0] d, input bit expect_frame);
    @(posedge clk);
    #1;
    bus.data_cnt = d;
    bus.snap     = 1'b1;
    if (expect_frame) exp_q.push_back(d);
    @(posedge clk);
    #1;
    bus.snap = 1'b0;
  endtask

  // Returns #1 after the edge on which done becomes visible.
  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  // Frame monitor: on each start bit pop the expected byte and check every cycle of the frame.
  initial begin : monitor
    logic [9:0] fb;
    logic [7:0] exp_b;
    logic [7:0] got;
    int         bad;
    bit         abort;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && bus.txd === 1'b0) begin
        chk("frame_queued", {31'd0, exp_q.size() != 0}, 32'd1);
        exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        fb    = {1'b1, exp_b, 1'b0};
        bad   = 0;
        abort = 1'b0;
        got   = '0;
        for (int j = 0; j < 10 * CPB; j++) begin
          if (j > 0) @(negedge clk);
          if (reset !== 1'b0) begin
            abort = 1'b1;
            break;
          end
          if (bus.txd !== fb[j / CPB] || bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
          if ((j % CPB) == CPB / 2 && j / CPB >= 1 && j / CPB <= 8) got[j / CPB - 1] = bus.txd;
        end
        if (!abort) begin
          chk("frame_bad_cycles", bad, 0);
          chk("frame_byte", {24'd0, got}, {24'd0, exp_b});
          @(negedge clk);
          chk("frame_done_pulse", {30'd0, bus.done, bus.busy}, 32'b10);
          frames_done++;
        end
      end
    end
  end

  initial begin : timeout
    #200000;
    $display("FAIL timeout: simulation did not finish, checks so far %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

  initial begin : stimulus
    bit seen;
    bus.data_cnt = '0;
    bus.snap     = 1'b0;
    bus.clr_ovr  = 1'b0;

    // Test 1: reset, idle, reset again mid-idle, release.
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("reset_outs", {28'd0, bus.txd, bus.busy, bus.done, bus.overrun}, 32'b1000);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_outs", {28'd0, bus.txd, bus.busy, bus.done, bus.overrun}, 32'b1000);
    end

    // Test 2: plain frame of 0x55.
    snap_pulse(8'h55, 1'b1);
    wait_done("t2_done");

    // Test 3: counter rewritten during the frame; the snapshot must stand.
    snap_pulse(8'hA3, 1'b1);
    @(posedge clk);
    #1 bus.data_cnt = 8'h00;
    wait_done("t3_done");

    // Test 4: overrun set, clear, and set-wins-over-clear.
    snap_pulse(8'h3C, 1'b1);
    repeat (8) @(posedge clk);
    snap_pulse(8'h99, 1'b0);
    @(negedge clk);
    chk("t4_ovr_set", {31'd0, bus.overrun}, 32'd1);
    @(posedge clk);
    #1 bus.clr_ovr = 1'b1;
    @(posedge clk);
    #1 bus.clr_ovr = 1'b0;
    @(negedge clk);
    chk("t4_ovr_clr", {31'd0, bus.overrun}, 32'd0);
    @(posedge clk);
    #1;
    bus.clr_ovr  = 1'b1;
    bus.snap     = 1'b1;
    bus.data_cnt = 8'h77;
    @(posedge clk);
    #1;
    bus.clr_ovr = 1'b0;
    bus.snap    = 1'b0;
    @(negedge clk);
    chk("t4_ovr_set_wins", {31'd0, bus.overrun}, 32'd1);
    wait_done("t4_done");
    bus.clr_ovr = 1'b1;
    @(posedge clk);
    #1 bus.clr_ovr = 1'b0;
    @(negedge clk);
    chk("t4_ovr_clr2", {31'd0, bus.overrun}, 32'd0);

    // Test 5: back-to-back, second snap on the done cycle.
    snap_pulse(8'h81, 1'b1);
    wait_done("t5_done_a");
    bus.data_cnt = 8'h0F;
    bus.snap     = 1'b1;
    exp_q.push_back(8'h0F);
    @(posedge clk);
    #1 bus.snap = 1'b0;
    chk("t5_b2b_start", {28'd0, bus.txd, bus.busy, bus.done, bus.overrun}, 32'b0100);
    wait_done("t5_done_b");

    // Test 6: reset mid-frame, then a clean 0xFF frame.
    snap_pulse(8'hC3, 1'b1);
    repeat (13) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_reset_abort", {29'd0, bus.txd, bus.busy, bus.done}, 32'b100);
    reset = 1'b0;
    seen  = 1'b0;
    repeat (45) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
    end
    chk("t6_quiet_after_reset", {31'd0, seen}, 32'd0);
    snap_pulse(8'hFF, 1'b1);
    wait_done("t6_done_ff");

    repeat (5) @(posedge clk);
    chk("frames_done", frames_done, 6);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
